// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and constants for the Goertzel power post-processing stage
package ft_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SQ1,
    ST_SQ2,
    ST_CROSS,
    ST_SUB,
    ST_WRITE,
    ST_DONE
  } ft_state_e;

  typedef enum logic [2:0] {
    MAC_NOP,
    MAC_LOAD,
    MAC_SQ1,
    MAC_SQ2,
    MAC_CROSS,
    MAC_SUB
  } mac_op_e;

  localparam int FT_NF     = 11;
  localparam int COEFF_ONE = 65536;
  localparam int COEFF_MAX = 131071;

  // Every bin's valid bit set, as seen by the STATUS register after a full frame.
  localparam logic [FT_NF-1:0] STATUS_HERZEL_ALL_MSK = {FT_NF{1'b1}};

  // Index width that stays legal when there is a single bin.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/power_mac.sv
// rtl/power_mac.sv - time-shared multiplier, accumulator and saturation for bin power
module power_mac
  import ft_pkg::*;
#(
  parameter int QW   = 32,
  parameter int CW   = 18,
  parameter int FRAC = 16,
  parameter int OSH  = 32,
  parameter int PW   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  mac_op_e              op_i,
  input  logic signed [QW-1:0] q1_i,
  input  logic signed [QW-1:0] q2_i,
  input  logic signed [CW-1:0] coeff_i,
  output logic [PW-1:0]        res_o
);

  localparam int MW   = (QW > CW) ? QW : CW;
  localparam int PRW  = QW + MW;
  localparam int ACCW = 2 * QW + 2;

  logic signed [QW-1:0]   q1_q, q2_q, r_q;
  logic signed [CW-1:0]   coeff_q;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [PW-1:0]          res_q;

  logic signed [QW-1:0]   mul_a;
  logic signed [MW-1:0]   mul_b;
  logic signed [PRW-1:0]  prod;
  logic signed [PRW-1:0]  cross_sh;
  logic signed [QW-1:0]   cross_sat;
  logic signed [ACCW-1:0] out_sh;
  logic [PW-1:0]          out_sat;

  // The only multiplier: operands are steered by the current operation.
  always_comb begin
    mul_a = q1_q;
    mul_b = MW'(q1_q);
    case (op_i)
      MAC_SQ2: begin
        mul_a = q2_q;
        mul_b = MW'(q2_q);
      end
      MAC_CROSS: begin
        mul_a = q1_q;
        mul_b = MW'(coeff_q);
      end
      MAC_SUB: begin
        mul_a = q2_q;
        mul_b = MW'(r_q);
      end
      default: begin
        mul_a = q1_q;
        mul_b = MW'(q1_q);
      end
    endcase
    prod = mul_a * mul_b;
  end

  always_comb begin
    cross_sh = prod >>> FRAC;
    if ((cross_sh[PRW-1:QW-1] == '0) || (cross_sh[PRW-1:QW-1] == '1)) begin
      cross_sat = cross_sh[QW-1:0];
    end else if (cross_sh[PRW-1]) begin
      cross_sat = {1'b1, {(QW-1){1'b0}}};
    end else begin
      cross_sat = {1'b0, {(QW-1){1'b1}}};
    end
  end

  always_comb begin
    acc_d = acc_q;
    case (op_i)
      MAC_SQ1: acc_d = ACCW'(prod);
      MAC_SQ2: acc_d = acc_q + ACCW'(prod);
      MAC_SUB: acc_d = acc_q - ACCW'(prod);
      default: acc_d = acc_q;
    endcase
  end

  // Result is formed from the post-SUB accumulator so it is ready in WRITE.
  always_comb begin
    out_sh = acc_d >>> OSH;
    if (out_sh[ACCW-1]) begin
      out_sat = '0;
    end else if (|out_sh[ACCW-2:PW]) begin
      out_sat = '1;
    end else begin
      out_sat = out_sh[PW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q1_q    <= '0;
      q2_q    <= '0;
      coeff_q <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      if (op_i == MAC_LOAD) begin
        q1_q    <= q1_i;
        q2_q    <= q2_i;
        coeff_q <= coeff_i;
      end
      if (op_i == MAC_CROSS) begin
        r_q <= cross_sat;
      end
      if (op_i == MAC_SUB) begin
        res_q <= out_sat;
      end
      acc_q <= acc_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/goertzel_power_seq.sv
// rtl/goertzel_power_seq.sv - sequences Goertzel bins through the shared power MAC
module goertzel_power_seq
  import ft_pkg::*;
#(
  parameter int NF   = FT_NF,
  parameter int QW   = 32,
  parameter int CW   = 18,
  parameter int FRAC = 16,
  parameter int OSH  = 32,
  parameter int PW   = 32,
  localparam int IW  = idx_width(NF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  output logic [IW-1:0]        bin_sel,
  input  logic signed [QW-1:0] q1,
  input  logic signed [QW-1:0] q2,
  input  logic signed [CW-1:0] coeff,
  output logic                 res_we,
  output logic [IW-1:0]        res_addr,
  output logic [PW-1:0]        res_data,
  output logic [NF-1:0]        valid_mask,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

  ft_state_e     state_q;
  logic [IW-1:0] idx_q, bin_sel_q, res_addr_q;
  logic          res_we_q, busy_q, done_q;
  logic [NF-1:0] valid_q;
  mac_op_e       op;

  // A clear squashes the MAC step of the current cycle so res_data holds.
  always_comb begin
    op = MAC_NOP;
    if (!clear) begin
      case (state_q)
        ST_WAIT:  op = MAC_LOAD;
        ST_SQ1:   op = MAC_SQ1;
        ST_SQ2:   op = MAC_SQ2;
        ST_CROSS: op = MAC_CROSS;
        ST_SUB:   op = MAC_SUB;
        default:  op = MAC_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      bin_sel_q  <= '0;
      res_addr_q <= '0;
      res_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= '0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      res_we_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      res_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            valid_q   <= '0;
            idx_q     <= '0;
            bin_sel_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT:  state_q <= ST_SQ1;
        ST_SQ1:   state_q <= ST_SQ2;
        ST_SQ2:   state_q <= ST_CROSS;
        ST_CROSS: state_q <= ST_SUB;
        ST_SUB: begin
          state_q        <= ST_WRITE;
          res_we_q       <= 1'b1;
          res_addr_q     <= idx_q;
          valid_q[idx_q] <= 1'b1;
        end
        ST_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q     <= idx_q + IW'(1);
            bin_sel_q <= idx_q + IW'(1);
            state_q   <= ST_FETCH;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  power_mac #(
    .QW  (QW),
    .CW  (CW),
    .FRAC(FRAC),
    .OSH (OSH),
    .PW  (PW)
  ) u_mac (
    .clk_i  (clk),
    .rst_i  (rst),
    .op_i   (op),
    .q1_i   (q1),
    .q2_i   (q2),
    .coeff_i(coeff),
    .res_o  (res_data)
  );

  assign bin_sel    = bin_sel_q;
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign valid_mask = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_goertzel_power_seq.sv
// tb/tb_goertzel_power_seq.sv - self-checking bench for goertzel_power_seq
module tb_goertzel_power_seq;
  import ft_pkg::*;

  localparam int NFB = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic               start_a, clear_a;
  logic [0:0]         bin_sel_a, res_addr_a, valid_a;
  logic signed [31:0] q1_a, q2_a;
  logic signed [17:0] coeff_a;
  logic               res_we_a, busy_a, done_a;
  logic [31:0]        res_data_a;

  logic               start_b, clear_b;
  logic [3:0]         bin_sel_b, res_addr_b, sel_d;
  logic signed [31:0] q1_b, q2_b;
  logic signed [17:0] coeff_b;
  logic               res_we_b, busy_b, done_b;
  logic [31:0]        res_data_b;
  logic [NFB-1:0]     valid_b;

  logic signed [31:0] mem_q1 [NFB];
  logic signed [31:0] mem_q2 [NFB];
  logic signed [17:0] mem_c  [NFB];
  logic [31:0]        exp_b  [NFB];

  goertzel_power_seq #(.NF(1), .OSH(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear(clear_a), .bin_sel(bin_sel_a),
    .q1(q1_a), .q2(q2_a), .coeff(coeff_a), .res_we(res_we_a), .res_addr(res_addr_a),
    .res_data(res_data_a), .valid_mask(valid_a), .busy(busy_a), .done(done_a)
  );

  goertzel_power_seq #(.NF(NFB), .OSH(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear(clear_b), .bin_sel(bin_sel_b),
    .q1(q1_b), .q2(q2_b), .coeff(coeff_b), .res_we(res_we_b), .res_addr(res_addr_b),
    .res_data(res_data_b), .valid_mask(valid_b), .busy(busy_b), .done(done_b)
  );

  // Upstream state array with one cycle of read latency.
  always @(posedge clk) sel_d <= bin_sel_b;
  assign q1_b    = (sel_d < 4'(NFB)) ? mem_q1[sel_d] : '0;
  assign q2_b    = (sel_d < 4'(NFB)) ? mem_q2[sel_d] : '0;
  assign coeff_b = (sel_d < 4'(NFB)) ? mem_c[sel_d]  : '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [127:0] floor_div(input logic signed [127:0] n,
                                                     input logic signed [127:0] d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic logic [31:0] ref_power(input logic signed [31:0] a, input logic signed [31:0] b,
                                            input logic signed [17:0] c, input int osh);
    logic signed [127:0] x, y, k, r, p, s, one;
    x = a;
    y = b;
    k = c;
    r = floor_div(x * k, 128'sd65536);
    if (r > 128'sd2147483647) r = 128'sd2147483647;
    if (r < -128'sd2147483648) r = -128'sd2147483648;
    p = x * x + y * y - r * y;
    one = 128'sd1;
    s = floor_div(p, one <<< osh);
    if (s < 0) return 32'd0;
    if (s > 128'sd4294967295) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  typedef struct {
    logic signed [31:0] q1;
    logic signed [31:0] q2;
    logic signed [17:0] c;
    logic [31:0]        exp;
    string              name;
  } vec_t;

  function automatic vec_t mk(input logic signed [31:0] a, input logic signed [31:0] b,
                              input logic signed [17:0] c, input logic [31:0] e, input string n);
    vec_t v;
    v.q1 = a; v.q2 = b; v.c = c; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic run_a(input vec_t v);
    q1_a = v.q1;
    q2_a = v.q2;
    coeff_a = v.c;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      check($sformatf("%s_we_c%0d", v.name, c), res_we_a, c == 7);
      check($sformatf("%s_done_c%0d", v.name, c), done_a, c == 8);
      check($sformatf("%s_busy_c%0d", v.name, c), busy_a, (c >= 1) && (c <= 7));
      if (c == 1) check($sformatf("%s_mask_c1", v.name), valid_a, 0);
      if (c == 7) begin
        check($sformatf("%s_data", v.name), res_data_a, v.exp);
        check($sformatf("%s_addr", v.name), res_addr_a, 0);
      end
      if (c >= 8) check($sformatf("%s_mask_c%0d", v.name, c), valid_a, 1);
    end
  endtask

  // abort_kind: 0 none, 1 clear (with a coincident start), 2 reset.
  task automatic run_b(input string tag, input int abort_kind, input int abort_at, input bit extra);
    bit aborted;
    int k, sel_exp, lw;
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      clear_b = 1'b0;
      rst = 1'b0;
      aborted = (abort_kind != 0) && (c > abort_at);
      check($sformatf("%s_we_c%0d", tag, c), res_we_b,
            !aborted && (c % 7 == 0) && (c / 7 >= 1) && (c / 7 <= NFB));
      if (!aborted && (c % 7 == 0) && (c / 7 >= 1) && (c / 7 <= NFB)) begin
        check($sformatf("%s_addr_c%0d", tag, c), res_addr_b, c / 7 - 1);
        check($sformatf("%s_data_c%0d", tag, c), res_data_b, exp_b[c / 7 - 1]);
      end
      check($sformatf("%s_done_c%0d", tag, c), done_b, !aborted && (c == 7 * NFB + 1));
      check($sformatf("%s_busy_c%0d", tag, c), busy_b, !aborted && (c <= 7 * NFB));
      sel_exp = aborted ? ((abort_kind == 2) ? 0 : (abort_at - 1) / 7) : (c - 1) / 7;
      if (sel_exp > NFB - 1) sel_exp = NFB - 1;
      check($sformatf("%s_sel_c%0d", tag, c), bin_sel_b, sel_exp);
      if (aborted) begin
        check($sformatf("%s_mask_c%0d", tag, c), valid_b, 0);
      end else if (c % 7 == 1) begin
        k = (c - 1) / 7;
        if (k > NFB) k = NFB;
        check($sformatf("%s_mask_c%0d", tag, c), valid_b, (1 << k) - 1);
      end
      if (abort_kind != 0 && c == abort_at + 1) begin
        lw = abort_at / 7 - 1;
        check($sformatf("%s_raddr_abort", tag), res_addr_b, (abort_kind == 2) ? 0 : lw);
        check($sformatf("%s_rdata_abort", tag), res_data_b, (abort_kind == 2) ? 0 : exp_b[lw]);
      end
      if (abort_kind == 1 && c == abort_at) begin
        clear_b = 1'b1;
        start_b = 1'b1;
      end
      if (abort_kind == 2 && c == abort_at) rst = 1'b1;
      if (extra && (c == 10 || c == 40 || c == 77)) start_b = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[$];
    rst = 1'b1;
    start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
    q1_a = '0; q2_a = '0; coeff_a = '0;
    for (int i = 0; i < NFB; i++) begin
      mem_q1[i] = '0; mem_q2[i] = '0; mem_c[i] = '0; exp_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_we_b", res_we_b, 0);
    check("rst_data_b", res_data_b, 0);
    check("rst_addr_b", res_addr_b, 0);
    check("rst_sel_b", bin_sel_b, 0);
    check("rst_mask_b", valid_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_done_b", done_b, 0);
    check("rst_mask_a", valid_a, 0);
    rst = 1'b0;

    vecs.push_back(mk(3, 4, 0, 25, "q3q4"));
    vecs.push_back(mk(10, 10, COEFF_ONE, 100, "c_one"));
    vecs.push_back(mk(10, 10, -COEFF_ONE, 300, "c_mone"));
    vecs.push_back(mk(2, 1, COEFF_MAX, 2, "c_max"));
    vecs.push_back(mk(-1, -1, COEFF_MAX, 0, "floor_neg"));
    vecs.push_back(mk(1 << 20, 1 << 20, 0, 32'hFFFF_FFFF, "sat_hi"));
    for (int i = 0; i < 4; i++) begin
      logic signed [31:0] a, b;
      logic signed [17:0] c;
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      c = 18'($urandom_range(0, 262143));
      vecs.push_back(mk(a, b, c, ref_power(a, b, c, 0), $sformatf("rnd%0d", i)));
    end
    foreach (vecs[i]) run_a(vecs[i]);

    for (int i = 0; i < NFB; i++) begin
      mem_q1[i] = $urandom();
      mem_q2[i] = $urandom();
      mem_c[i]  = 18'($urandom_range(0, 262143));
    end
    mem_q1[0] = 3; mem_q2[0] = 4; mem_c[0] = 0;
    mem_q1[1] = 32'h8000_0000; mem_q2[1] = 32'h8000_0000; mem_c[1] = -18'sd131072;
    for (int i = 0; i < NFB; i++) exp_b[i] = ref_power(mem_q1[i], mem_q2[i], mem_c[i], 32);

    run_b("full", 0, 0, 1'b0);
    check("full_all_mask", valid_b, STATUS_HERZEL_ALL_MSK);
    run_b("clr", 1, 30, 1'b0);
    run_b("rst", 2, 20, 1'b0);
    run_b("rerun", 0, 0, 1'b1);
    check("rerun_all_mask", valid_b, STATUS_HERZEL_ALL_MSK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/goertzel_power_seq.md
Name: goertzel_power_seq

Overview:
- Post-processing stage directly downstream of the Goertzel bin accumulators in the FourierTransform datapath.
- After a frame of NS samples, it sequentially reads the final state (q1, q2) and coefficient of each of NF bins.
- It computes the bin power P = q1^2 + q2^2 - coeff*q1*q2 with one shared signed multiplier.
- It writes P into the DATA_x result register file and sets per-bin valid bits for the STATUS register.

Parameters:
- NF, 11: number of frequency bins.
- QW, 32: width of signed Goertzel state q1/q2.
- CW, 18: width of signed coefficient 2cos(w), Q2.16 format.
- FRAC, 16: coefficient fraction bits.
- OSH, 32: arithmetic right shift applied to the accumulator before output.
- PW, 32: result width, unsigned.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse: all bin states are final
- clear  in  1  single-cycle pulse: invalidate results, abort sequence
- bin_sel  out  $clog2(NF)  bin index requested from upstream state array
- q1  in  QW signed  state of bin_sel, valid 1 cycle after bin_sel changes
- q2  in  QW signed  same timing as q1
- coeff  in  CW signed  coefficient of bin_sel, same timing
- res_we  out  1  result write strobe
- res_addr  out  $clog2(NF)  result bin index
- res_data  out  PW  bin power
- valid_mask  out  NF  bit i set when bin i result is written
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  single-cycle pulse after the last bin is written

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs are 0; FSM returns to IDLE; accumulator and registers clear. Reset mid-sequence aborts with no further writes and no done.
- FSM states: IDLE, FETCH, WAIT, SQ1, SQ2, CROSS, SUB, WRITE, DONE.
- IDLE: if start=1 and clear=0, clear valid_mask, set bin index to 0, go to FETCH.
- FETCH: drive bin_sel = index, go to WAIT. bin_sel holds its value until the next FETCH.
- WAIT: allows the 1-cycle upstream read latency; at the end of WAIT, capture q1, q2 and coeff into local registers.
- SQ1: acc = q1*q1. acc is signed, width 2*QW+2.
- SQ2: acc += q2*q2.
- CROSS: r = (q1*coeff) >>> FRAC (floor), saturated to signed QW.
- SUB: acc -= r*q2.
- WRITE: res_we=1, res_addr=index, res_data=sat(acc >>> OSH); set valid_mask[index].
  - If index==NF-1, go to DONE; otherwise index+1, go to FETCH.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle done pulses.
- Output saturation: negative shifted values (floor rounding) clamp to 0; values above 2^PW-1 clamp to 2^PW-1.
- Timing: each bin takes exactly 7 cycles. If start is sampled at edge 0, the WRITE for bin k occurs in cycle 7k+7 and done occurs in cycle 7*NF+1 (78 for NF=11).
- Edge cases:
  - start while busy is ignored.
  - clear has priority over start in the same cycle. In any state, clear zeroes valid_mask and returns to IDLE next cycle, with no res_we and no done.
  - res_we is high only in WRITE; res_addr and res_data hold their last values otherwise.
  - NF=1 is legal: one bin, done in cycle 8.
  - The bin index never wraps past NF-1.
- Multiplier: a single QW x max(QW,CW) signed multiplier is time-shared across SQ1, SQ2, CROSS and SUB, with operand muxes selected by state. No other multipliers.

Decomposition:
- Shared package ft_pkg:
  - FSM state enum.
  - Q2.16 constants COEFF_ONE=65536 and COEFF_MAX=131071.
  - STATUS_HERZEL_ALL_MSK, derived as NF ones and consumed by the STATUS register.
- One natural sub-module, power_mac: shared multiplier, accumulator, cross-term saturation and output shift/saturation, controlled by an op-select input from the FSM.

Test Plan:
1. NF=1, OSH=0; q1=3, q2=4, coeff=0 -> res_data=25 in cycle 7; done in cycle 8; valid_mask=1.
2. OSH=0; coeff=65536 (1.0), q1=q2=10 -> 100. coeff=-65536 -> 300. q1=2, q2=1, coeff=131071 -> cross=3, result 2.
3. OSH=0; q1=q2=-1, coeff=131071 -> floor gives cross=-2, result 0. q1=q2=2^20, coeff=0 -> saturates to 0xFFFFFFFF.
4. NF=11, OSH=32, distinct per-bin states matching a reference model:
   - res_addr sequence is 0..10, writes in cycles 7,14,...,77;
   - bin_sel changes only in FETCH; done in cycle 78;
   - valid_mask=0x7FF and busy low afterwards.
5. clear in cycle 30 of an NF=11 run -> valid_mask=0 next cycle, FSM in IDLE, no further res_we, no done. A start in the same cycle as clear is ignored.
6. rst in cycle 20 -> all outputs 0 next cycle. A fresh start then completes normally in 78 cycles. start pulses during busy do not restart or extend the sequence.
